// File: rtl/universal_shift_reg_if.sv
// Bus interface for universal_shift_reg.
// Carries the operation controls, the parallel and serial data, and the status outputs.
interface universal_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic             start;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  // The driver side issues operations and observes the register.
  modport master (
    output en, mode, d, sin, start, amt,
    input  q, sout, busy, done
  );

  // The register side accepts operations and presents its state.
  modport slave (
    input  en, mode, d, sin, start, amt,
    output q, sout, busy, done
  );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register.
// Single-step operations run from IDLE when en is high. A start request with a
// shift or rotate mode runs amt steps of that mode, one step per clock.
// busy is high while those steps run; done pulses for one cycle at the end.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input logic                  clk,
  input logic                  reset,
  universal_shift_reg_if.slave bus
);

  localparam logic [2:0] M_HOLD  = 3'd0;
  localparam logic [2:0] M_LOAD  = 3'd1;
  localparam logic [2:0] M_SHL   = 3'd2;
  localparam logic [2:0] M_SHR   = 3'd3;
  localparam logic [2:0] M_ROTL  = 3'd4;
  localparam logic [2:0] M_ROTR  = 3'd5;
  localparam logic [2:0] M_ASR   = 3'd6;
  localparam logic [2:0] M_CLEAR = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_l_q, mode_l_d;
  logic             sin_l_q, sin_l_d;

  // Returns {sout, q} after one shift/rotate step. Modes that shift nothing
  // out leave both the value and the previous sout untouched.
  function automatic logic [WIDTH:0] step_fn(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] v,
    input logic             s_in,
    input logic             s_old
  );
    case (m)
      M_SHL:   step_fn = {v[WIDTH-1], v[WIDTH-2:0], s_in};
      M_SHR:   step_fn = {v[0], s_in, v[WIDTH-1:1]};
      M_ROTL:  step_fn = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      M_ROTR:  step_fn = {v[0], v[0], v[WIDTH-1:1]};
      M_ASR:   step_fn = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: step_fn = {s_old, v};
    endcase
  endfunction

  function automatic logic is_shift(input logic [2:0] m);
    is_shift = (m >= M_SHL) && (m <= M_ASR);
  endfunction

  // Next-state logic: FSM transitions, register update and step counting.
  always_comb begin
    // NOTE: every signal gets a default first so that no path leaves one unassigned, which would infer a latch.
    state_d  = state_q;
    q_d      = q_q;
    sout_d   = sout_q;
    cnt_d    = cnt_q;
    mode_l_d = mode_l_q;
    sin_l_d  = sin_l_q;
    case (state_q)
      IDLE: begin
        if (bus.start && is_shift(bus.mode)) begin
          mode_l_d = bus.mode;
          sin_l_d  = bus.sin;
          cnt_d    = bus.amt;
          state_d  = (bus.amt == '0) ? DONE : RUN;
        end else if (bus.en) begin
          case (bus.mode)
            M_HOLD:  q_d = q_q;
            M_LOAD:  q_d = bus.d;
            M_CLEAR: q_d = '0;
            default: {sout_d, q_d} = step_fn(bus.mode, q_q, bus.sin, sout_q);
          endcase
        end
      end
      RUN: begin
        {sout_d, q_d} = step_fn(mode_l_q, q_q, sin_l_q, sout_q);
        cnt_d         = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q  <= IDLE;
      q_q      <= '0;
      sout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      mode_l_q <= M_HOLD;
      sin_l_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      sout_q   <= sout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      mode_l_q <= mode_l_d;
      sin_l_q  <= sin_l_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.sout = sout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Testbench for universal_shift_reg (WIDTH=8, AMT_W=4 so a shift by 8 fits).
// The driver applies one directed vector per clock and queues the expected
// register state after that edge; the monitor pops and compares each cycle.
module tb_universal_shift_reg;

  localparam int WIDTH = 8;
  localparam int AMT_W = 4;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  int   n_vec;
  int   n_bad;

  universal_shift_reg_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  universal_shift_reg #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic apply(
    input string      name,
    input logic       rst,
    input logic       en,
    input logic [2:0] mode,
    input logic [7:0] d,
    input logic       sin,
    input logic       start,
    input logic [3:0] amt,
    input logic [7:0] eq,
    input logic       es,
    input logic       eb,
    input logic       ed
  );
    exp_t e;
    @(negedge clk);
    reset     = rst;
    bus.en    = en;
    bus.mode  = mode;
    bus.d     = d;
    bus.sin   = sin;
    bus.start = start;
    bus.amt   = amt;
    e.name = name;
    e.q    = eq;
    e.sout = es;
    e.busy = eb;
    e.done = ed;
    exp_q.push_back(e);
  endtask

  // Quiet cycle: no enable, no start.
  task automatic idle(input string name, input logic [7:0] eq, input logic es,
                      input logic eb, input logic ed);
    apply(name, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0, eq, es, eb, ed);
  endtask

  // Monitor: one comparison per clock while expectations are pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (bus.q !== e.q || bus.sout !== e.sout || bus.busy !== e.busy || bus.done !== e.done) begin
          n_bad++;
          $display("FAIL %s: got q=%h sout=%b busy=%b done=%b, want q=%h sout=%b busy=%b done=%b",
                   e.name, bus.q, bus.sout, bus.busy, bus.done, e.q, e.sout, e.busy, e.done);
        end
      end
    end
  end

  // SHL-by-8 trajectory from 8'hD2 with sin=0: {q, sout} after each step.
  logic [7:0] shl8_q [8];
  logic       shl8_s [8];

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.en = 1'b0; bus.mode = 3'd0; bus.d = '0; bus.sin = 1'b0; bus.start = 1'b0; bus.amt = '0;
    shl8_q = '{8'hA4, 8'h48, 8'h90, 8'h20, 8'h40, 8'h80, 8'h00, 8'h00};
    shl8_s = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    //     name           rst  en    mode  d      sin   start amt    q      sout  busy  done
    apply("reset0",       1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    apply("reset1",       1'b1, 1'b1, 3'd1, 8'hFF, 1'b1, 1'b1, 4'd3, 8'h00, 1'b0, 1'b0, 1'b0);
    apply("load_b5",      1'b0, 1'b1, 3'd1, 8'hB5, 1'b0, 1'b0, 4'd0, 8'hB5, 1'b0, 1'b0, 1'b0);
    apply("rotl",         1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 4'd0, 8'h6B, 1'b1, 1'b0, 1'b0);
    apply("load_81",      1'b0, 1'b1, 3'd1, 8'h81, 1'b0, 1'b0, 4'd0, 8'h81, 1'b1, 1'b0, 1'b0);
    apply("asr",          1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 4'd0, 8'hC0, 1'b1, 1'b0, 1'b0);
    apply("shr_sin0",     1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h60, 1'b0, 1'b0, 1'b0);
    apply("hold",         1'b0, 1'b1, 3'd0, 8'hFF, 1'b1, 1'b0, 4'd0, 8'h60, 1'b0, 1'b0, 1'b0);
    apply("en_low",       1'b0, 1'b0, 3'd1, 8'hFF, 1'b1, 1'b0, 4'd0, 8'h60, 1'b0, 1'b0, 1'b0);
    apply("shl_sin1",     1'b0, 1'b1, 3'd2, 8'h00, 1'b1, 1'b0, 4'd0, 8'hC1, 1'b0, 1'b0, 1'b0);
    apply("rotr",         1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 4'd0, 8'hE0, 1'b1, 1'b0, 1'b0);
    apply("clear",        1'b0, 1'b1, 3'd7, 8'hAA, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    apply("load_01",      1'b0, 1'b1, 3'd1, 8'h01, 1'b0, 1'b0, 4'd0, 8'h01, 1'b1, 1'b0, 1'b0);

    // Multi-cycle SHL by 3 with sin=1.
    apply("shl3_start",   1'b0, 1'b0, 3'd2, 8'h00, 1'b1, 1'b1, 4'd3, 8'h01, 1'b1, 1'b1, 1'b0);
    idle ("shl3_step1",   8'h03, 1'b0, 1'b1, 1'b0);
    idle ("shl3_step2",   8'h07, 1'b0, 1'b1, 1'b0);
    idle ("shl3_step3",   8'h0F, 1'b0, 1'b0, 1'b1);
    idle ("shl3_after",   8'h0F, 1'b0, 1'b0, 1'b0);

    // amt=0 completes at once; start with a non-shift mode is a plain load.
    apply("amt0_start",   1'b0, 1'b0, 3'd4, 8'h00, 1'b0, 1'b1, 4'd0, 8'h0F, 1'b0, 1'b0, 1'b1);
    idle ("amt0_after",   8'h0F, 1'b0, 1'b0, 1'b0);
    apply("start_load",   1'b0, 1'b1, 3'd1, 8'h3C, 1'b0, 1'b1, 4'd3, 8'h3C, 1'b0, 1'b0, 1'b0);
    idle ("start_load_2", 8'h3C, 1'b0, 1'b0, 1'b0);

    // Reset in the second RUN cycle of ROTR by 5.
    apply("rotr5_start",  1'b0, 1'b0, 3'd5, 8'h00, 1'b0, 1'b1, 4'd5, 8'h3C, 1'b0, 1'b1, 1'b0);
    idle ("rotr5_step1",  8'h1E, 1'b0, 1'b1, 1'b0);
    apply("rotr5_reset",  1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    apply("post_rst_ld",  1'b0, 1'b1, 3'd1, 8'hA5, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0);
    idle ("post_rst_idl", 8'hA5, 1'b0, 1'b0, 1'b0);

    // start and en together; inputs toggled during RUN and DONE are ignored.
    apply("shr2_start",   1'b0, 1'b1, 3'd3, 8'hFF, 1'b1, 1'b1, 4'd2, 8'hA5, 1'b0, 1'b1, 1'b0);
    apply("shr2_step1",   1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 1'b1, 4'd7, 8'hD2, 1'b1, 1'b1, 1'b0);
    apply("shr2_step2",   1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 4'd0, 8'hE9, 1'b0, 1'b0, 1'b1);
    apply("done_start",   1'b0, 1'b1, 3'd2, 8'h00, 1'b0, 1'b1, 4'd1, 8'hE9, 1'b0, 1'b0, 1'b0);
    apply("idle_start",   1'b0, 1'b0, 3'd2, 8'h00, 1'b0, 1'b1, 4'd1, 8'hE9, 1'b0, 1'b1, 1'b0);
    idle ("shl1_step",    8'hD2, 1'b1, 1'b0, 1'b1);
    idle ("shl1_after",   8'hD2, 1'b1, 1'b0, 1'b0);

    // Shift amount equal to WIDTH clears the register.
    apply("shl8_start",   1'b0, 1'b0, 3'd2, 8'h00, 1'b0, 1'b1, 4'd8, 8'hD2, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      idle($sformatf("shl8_step%0d", i + 1), shl8_q[i], shl8_s[i], (i < 7), (i == 7));
    idle ("shl8_after",   8'h00, 1'b0, 1'b0, 1'b0);

    // Multi-cycle arithmetic shift keeps the sign bit.
    apply("load_90",      1'b0, 1'b1, 3'd1, 8'h90, 1'b0, 1'b0, 4'd0, 8'h90, 1'b0, 1'b0, 1'b0);
    apply("asr2_start",   1'b0, 1'b0, 3'd6, 8'h00, 1'b1, 1'b1, 4'd2, 8'h90, 1'b0, 1'b1, 1'b0);
    idle ("asr2_step1",   8'hC8, 1'b0, 1'b1, 1'b0);
    idle ("asr2_step2",   8'hE4, 1'b0, 1'b0, 1'b1);
    idle ("asr2_after",   8'hE4, 1'b0, 1'b0, 1'b0);

    // Let the monitor drain, with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
